// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALU operation codes, mux encodings,
// the multi-cycle FSM state set and small decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNC_SLL = 6'b000000;
    localparam logic [5:0] FUNC_SRL = 6'b000010;
    localparam logic [5:0] FUNC_SRA = 6'b000011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS    = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTEXEC  = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_IMMEXEC = 4'd10,
        ST_IMMWB   = 4'd11,
        ST_TRAP    = 4'd12,
        ST_BUSERR  = 4'd13
    } state_t;

    typedef struct packed {
        logic       sign_ext;
        logic [3:0] alu_op;
    } imm_ctrl_t;

    function automatic imm_ctrl_t imm_ctrl(input logic [5:0] opcode);
        case (opcode)
            OP_ORI:   return '{sign_ext: 1'b0, alu_op: ALU_OR};
            OP_ADDI:  return '{sign_ext: 1'b1, alu_op: ALU_ADD};
            OP_ADDIU: return '{sign_ext: 1'b1, alu_op: ALU_ADDU};
            OP_ANDI:  return '{sign_ext: 1'b0, alu_op: ALU_AND};
            OP_LUI:   return '{sign_ext: 1'b0, alu_op: ALU_LUI};
            OP_SLTI:  return '{sign_ext: 1'b1, alu_op: ALU_SLT};
            OP_SLTIU: return '{sign_ext: 1'b1, alu_op: ALU_SLTU};
            OP_XORI:  return '{sign_ext: 1'b0, alu_op: ALU_XOR};
            default:  return '{sign_ext: 1'b0, alu_op: ALU_ADD};
        endcase
    endfunction

    function automatic state_t decode_target(input logic [5:0] opcode, input logic bne_en);
        case (opcode)
            OP_RTYPE:                        return ST_RTEXEC;
            OP_LW, OP_SW:                    return ST_MEMADR;
            OP_BEQ:                          return ST_BRANCH;
            OP_BNE:                          return bne_en ? ST_BRANCH : ST_TRAP;
            OP_J:                            return ST_JUMP;
            OP_ORI, OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_LUI, OP_SLTI, OP_SLTIU, OP_XORI: return ST_IMMEXEC;
            default:                         return ST_TRAP;
        endcase
    endfunction

    function automatic logic is_shift_func(input logic [5:0] func);
        return (func == FUNC_SLL) || (func == FUNC_SRL) || (func == FUNC_SRA);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-access watchdog: counts wait cycles of the current access and flags
// a timeout on the cycle whose wait would bring the count to MEM_TIMEOUT.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    logic [CW-1:0] count_r;

    // Wait-cycle counter; saturates at the last allowed wait since the FSM leaves on timeout
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= '0;
        end else if (waiting && !mem_ready && (count_r != LAST)) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    // A ready in the final allowed cycle still completes the access
    assign timeout = (MEM_TIMEOUT > 0) && waiting && !mem_ready && (count_r == LAST);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with a memory ready handshake, watchdog, optional BNE and illegal-opcode trap.
module multi_cycle_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit ENABLE_BNE  = 1'b1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       SignExtend,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic       BusError,
    output logic [3:0] State
);
    state_t    state_r;
    state_t    next_state_s;
    logic      timeout_s;
    logic      wd_wait_s;
    logic      wd_clear_s;
    imm_ctrl_t imm_s;

    assign wd_wait_s  = (state_r == ST_FETCH) || (state_r == ST_MEMRD) || (state_r == ST_MEMWR);
    assign wd_clear_s = (next_state_s != state_r) &&
                        ((next_state_s == ST_FETCH) || (next_state_s == ST_MEMRD) ||
                         (next_state_s == ST_MEMWR));
    assign imm_s      = imm_ctrl(Opcode);
    assign State      = state_r;

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk       (CLK),
        .reset     (Reset),
        .clear     (wd_clear_s),
        .waiting   (wd_wait_s),
        .mem_ready (MemReady),
        .timeout   (timeout_s)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (timeout_s)     next_state_s = ST_BUSERR;
                else if (MemReady) next_state_s = ST_DECODE;
                else               next_state_s = ST_FETCH;
            end
            ST_DECODE:  next_state_s = decode_target(Opcode, ENABLE_BNE);
            ST_MEMADR:  next_state_s = (Opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (timeout_s)     next_state_s = ST_BUSERR;
                else if (MemReady) next_state_s = ST_MEMWB;
                else               next_state_s = ST_MEMRD;
            end
            ST_MEMWR: begin
                if (timeout_s)     next_state_s = ST_BUSERR;
                else if (MemReady) next_state_s = ST_FETCH;
                else               next_state_s = ST_MEMWR;
            end
            ST_RTEXEC:  next_state_s = ST_ALUWB;
            ST_IMMEXEC: next_state_s = ST_IMMWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_IMMWB, ST_TRAP:
                        next_state_s = ST_FETCH;
            ST_BUSERR:  next_state_s = ST_BUSERR;
            default:    next_state_s = ST_FETCH;
        endcase
    end

    // Output decode; only FETCH looks at MemReady
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        SignExtend  = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALU_AND;
        PCSource    = PCSRC_ALU;
        Illegal     = 1'b0;
        BusError    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALU_ADD;
                end else begin
                    IRWrite = 1'b0;
                    PCWrite = 1'b0;
                end
            end
            ST_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                SignExtend = 1'b1;
                ALUOp      = ALU_ADD;
            end
            ST_MEMADR: begin
                ALUSrcA    = SRCA_RS;
                ALUSrcB    = SRCB_IMM;
                SignExtend = 1'b1;
                ALUOp      = ALU_ADD;
            end
            ST_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            ST_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_RTEXEC, ST_ALUWB: begin
                ALUSrcA  = is_shift_func(Func) ? SRCA_SHAMT : SRCA_RS;
                ALUOp    = ALU_FUNC;
                RegDst   = (state_r == ST_ALUWB);
                RegWrite = (state_r == ST_ALUWB);
            end
            ST_BRANCH: begin
                ALUSrcA     = SRCA_RS;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = (Opcode == OP_BNE);
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            ST_IMMEXEC, ST_IMMWB: begin
                ALUSrcA    = SRCA_RS;
                ALUSrcB    = SRCB_IMM;
                SignExtend = imm_s.sign_ext;
                ALUOp      = imm_s.alu_op;
                RegWrite   = (state_r == ST_IMMWB);
            end
            ST_TRAP: begin
                Illegal  = 1'b1;
                PCWrite  = 1'b1;
                PCSource = PCSRC_EXC;
            end
            ST_BUSERR: BusError = 1'b1;
            default:   BusError = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: table vectors, random instruction
// streams against an instruction-level reference model, and watchdog/reset corners.
module tb_multi_cycle_control;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Opcode = 6'b000000;
    logic [5:0] Func = 6'b000000;
    logic       MemReady = 1'b0;

    // index 0: MEM_TIMEOUT=16, BNE on; index 1: MEM_TIMEOUT=4, BNE off
    logic [1:0] pcw, pcwc, bne, iord, mrd, mwr, irw, rdst, m2r, rw, sx, ill, berr;
    logic [1:0] srca [2];
    logic [1:0] srcb [2];
    logic [3:0] aop [2];
    logic [1:0] pcs [2];
    logic [3:0] st [2];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    multi_cycle_control #(.MEM_TIMEOUT(16), .ENABLE_BNE(1'b1)) dut_a (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Func(Func), .MemReady(MemReady),
        .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .BranchNe(bne[0]), .IorD(iord[0]),
        .MemRead(mrd[0]), .MemWrite(mwr[0]), .IRWrite(irw[0]), .RegDst(rdst[0]),
        .MemToReg(m2r[0]), .RegWrite(rw[0]), .SignExtend(sx[0]), .ALUSrcA(srca[0]),
        .ALUSrcB(srcb[0]), .ALUOp(aop[0]), .PCSource(pcs[0]), .Illegal(ill[0]),
        .BusError(berr[0]), .State(st[0])
    );

    multi_cycle_control #(.MEM_TIMEOUT(4), .ENABLE_BNE(1'b0)) dut_b (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Func(Func), .MemReady(MemReady),
        .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .BranchNe(bne[1]), .IorD(iord[1]),
        .MemRead(mrd[1]), .MemWrite(mwr[1]), .IRWrite(irw[1]), .RegDst(rdst[1]),
        .MemToReg(m2r[1]), .RegWrite(rw[1]), .SignExtend(sx[1]), .ALUSrcA(srca[1]),
        .ALUSrcB(srcb[1]), .ALUOp(aop[1]), .PCSource(pcs[1]), .Illegal(ill[1]),
        .BusError(berr[1]), .State(st[1])
    );

    logic [3:0] imm_aop [8] = '{4'b0010, 4'b1000, 4'b0111, 4'b1011,
                                4'b0000, 4'b0001, 4'b1010, 4'b1110};
    logic [5:0] ops [14] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                             6'b000010, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                             6'b001100, 6'b001101, 6'b001110, 6'b001111};

    int  path_st [$];
    bit  path_mr [$];

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         fw;
        int         mw;
        int         d;
        int         cycles;
    } vec_t;
    vec_t vecs [15];

    // vector: {PCWrite,PCWriteCond,BranchNe,IorD,MemRead,MemWrite,IRWrite,RegDst,
    //          MemToReg,RegWrite,SignExtend,ALUSrcA,ALUSrcB,ALUOp,PCSource,Illegal,BusError,State}
    function automatic logic [26:0] got(input int d);
        return {pcw[d], pcwc[d], bne[d], iord[d], mrd[d], mwr[d], irw[d], rdst[d], m2r[d],
                rw[d], sx[d], srca[d], srcb[d], aop[d], pcs[d], ill[d], berr[d], st[d]};
    endfunction

    function automatic logic [26:0] exp_out(input int s, input logic [5:0] op,
                                            input logic [5:0] fn, input bit mr);
        logic p_w, p_c, b_n, i_d, m_r, m_w, i_w, r_d, m_2, r_w, s_x, il, be;
        logic [1:0] sa, sb, ps;
        logic [3:0] ao;
        logic [3:0] s4;
        {p_w, p_c, b_n, i_d, m_r, m_w, i_w, r_d, m_2, r_w, s_x, il, be} = 13'd0;
        sa = 2'b00; sb = 2'b00; ps = 2'b00; ao = 4'b0000;
        s4 = 4'(s);
        case (s)
            0: begin m_r = 1'b1; if (mr) begin i_w = 1'b1; p_w = 1'b1; sb = 2'b01; ao = 4'b0010; end end
            1: begin sb = 2'b11; s_x = 1'b1; ao = 4'b0010; end
            2: begin sa = 2'b01; sb = 2'b10; s_x = 1'b1; ao = 4'b0010; end
            3: begin i_d = 1'b1; m_r = 1'b1; end
            4: begin m_2 = 1'b1; r_w = 1'b1; end
            5: begin i_d = 1'b1; m_w = 1'b1; end
            6, 7: begin
                sa = (fn == 6'd0 || fn == 6'd2 || fn == 6'd3) ? 2'b10 : 2'b01;
                ao = 4'b1111;
                r_d = (s == 7); r_w = (s == 7);
            end
            8: begin sa = 2'b01; ao = 4'b0110; p_c = 1'b1; ps = 2'b01; b_n = (op == 6'b000101); end
            9: begin p_w = 1'b1; ps = 2'b10; end
            10, 11: begin sa = 2'b01; sb = 2'b10; s_x = ~op[2]; ao = imm_aop[op[2:0]]; r_w = (s == 11); end
            12: begin il = 1'b1; p_w = 1'b1; ps = 2'b11; end
            13: be = 1'b1;
            default: be = 1'b0;
        endcase
        return {p_w, p_c, b_n, i_d, m_r, m_w, i_w, r_d, m_2, r_w, s_x, sa, sb, ao, ps, il, be, s4};
    endfunction

    // 0 R-type, 1 LW, 2 SW, 3 branch, 4 jump, 5 immediate, 6 trap
    function automatic int class_of(input logic [5:0] op, input bit bne_en);
        if (op == 6'b000000) return 0;
        if (op == 6'b100011) return 1;
        if (op == 6'b101011) return 2;
        if (op == 6'b000100 || (op == 6'b000101 && bne_en)) return 3;
        if (op == 6'b000010) return 4;
        if (op[5:3] == 3'b001) return 5;
        return 6;
    endfunction

    function automatic void push(input int s, input bit mr);
        path_st.push_back(s);
        path_mr.push_back(mr);
    endfunction

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
                     name, act, act[3:0], exp, exp[3:0], $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        MemReady = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b0;
    endtask

    task automatic step(input string name, input int d, input logic [26:0] exp);
        @(negedge CLK);
        chk(name, got(d), exp);
        @(posedge CLK); #1;
    endtask

    // Builds the expected state walk for one instruction, drives it, checks every cycle
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input int d, output int cycles, output int irw_cnt);
        logic [26:0] g;
        logic [3:0]  now;
        bit          left0;
        path_st.delete();
        path_mr.delete();
        for (int i = 0; i < fw; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, bit'($urandom_range(0, 1)));
        case (class_of(op, d == 0))
            0: begin push(6, bit'($urandom_range(0, 1))); push(7, bit'($urandom_range(0, 1))); end
            1: begin
                push(2, bit'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) push(3, 1'b0);
                push(3, 1'b1);
                push(4, bit'($urandom_range(0, 1)));
            end
            2: begin
                push(2, bit'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            3: push(8, bit'($urandom_range(0, 1)));
            4: push(9, bit'($urandom_range(0, 1)));
            5: begin push(10, bit'($urandom_range(0, 1))); push(11, bit'($urandom_range(0, 1))); end
            default: push(12, bit'($urandom_range(0, 1)));
        endcase
        cycles = 0;
        irw_cnt = 0;
        left0 = 1'b0;
        for (int i = 0; i < path_st.size(); i++) begin
            Opcode = op;
            Func = fn;
            MemReady = path_mr[i];
            @(negedge CLK);
            g = got(d);
            chk("cycle", g, exp_out(path_st[i], op, fn, path_mr[i]));
            if (g[20]) irw_cnt++;
            @(posedge CLK); #1;
            g = got(d);
            now = g[3:0];
            if (now != 4'd0) left0 = 1'b1;
            else if (left0 && cycles == 0) cycles = i + 1;
        end
    endtask

    initial begin
        int cyc;
        int irc;
        logic [5:0] op;
        logic [5:0] fn;

        vecs[0]  = '{6'b000000, 6'b100000, 0, 0, 0, 4};
        vecs[1]  = '{6'b100011, 6'b000000, 3, 2, 0, 10};
        vecs[2]  = '{6'b101011, 6'b000000, 0, 0, 0, 4};
        vecs[3]  = '{6'b000100, 6'b000000, 0, 0, 0, 3};
        vecs[4]  = '{6'b000101, 6'b000000, 0, 0, 0, 3};
        vecs[5]  = '{6'b000101, 6'b000000, 0, 0, 1, 3};
        vecs[6]  = '{6'b000010, 6'b000000, 0, 0, 0, 3};
        vecs[7]  = '{6'b000000, 6'b000000, 0, 0, 0, 4};
        vecs[8]  = '{6'b001100, 6'b000000, 0, 0, 0, 4};
        vecs[9]  = '{6'b001011, 6'b000000, 0, 0, 0, 4};
        vecs[10] = '{6'b001111, 6'b000000, 0, 0, 0, 4};
        vecs[11] = '{6'b111111, 6'b000000, 0, 0, 0, 3};
        vecs[12] = '{6'b100011, 6'b000000, 15, 15, 0, 35};
        vecs[13] = '{6'b101011, 6'b000000, 0, 3, 1, 7};
        vecs[14] = '{6'b100011, 6'b000000, 3, 3, 1, 11};

        // Reset values while Reset is held
        Reset = 1'b1;
        MemReady = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_a", got(0), exp_out(0, 6'd0, 6'd0, 1'b0));
        chk("reset_b", got(1), exp_out(0, 6'd0, 6'd0, 1'b0));
        @(posedge CLK); #1;
        Reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_reset();
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].fw, vecs[i].mw, vecs[i].d, cyc, irc);
            chk_int($sformatf("cycles_row%0d", i), cyc, vecs[i].cycles);
            chk_int($sformatf("irwrite_once_row%0d", i), irc, 1);
        end

        // Random instruction stream, back to back
        do_reset();
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            fn = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(2, 3)) : 6'($urandom);
            if ($urandom_range(0, 5) == 0) fn = 6'b000000;
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 0, cyc, irc);
            chk_int("rand_irwrite", irc, 1);
        end

        // Fetch timeout on the 4-cycle watchdog, same waits harmless on the 16-cycle one
        do_reset();
        Opcode = 6'b101011;
        Func = 6'b000000;
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) step("wd_fetch_wait", 1, exp_out(0, Opcode, Func, 1'b0));
        @(negedge CLK);
        chk("wd_fetch_buserr", got(1), exp_out(13, Opcode, Func, 1'b0));
        chk("wd_a_no_timeout", got(0), exp_out(0, Opcode, Func, 1'b0));
        @(posedge CLK); #1;

        // SW stuck in MEMWR: BUSERR after 4 waits, sticky, cleared only by Reset
        do_reset();
        MemReady = 1'b1;
        step("wd_sw_fetch", 1, exp_out(0, Opcode, Func, 1'b1));
        MemReady = 1'b0;
        step("wd_sw_decode", 1, exp_out(1, Opcode, Func, 1'b0));
        step("wd_sw_memadr", 1, exp_out(2, Opcode, Func, 1'b0));
        for (int i = 0; i < 4; i++) step("wd_sw_wait", 1, exp_out(5, Opcode, Func, 1'b0));
        step("wd_sw_buserr", 1, exp_out(13, Opcode, Func, 1'b0));
        MemReady = 1'b1;
        step("wd_sticky", 1, exp_out(13, Opcode, Func, 1'b1));
        step("wd_sticky", 1, exp_out(13, Opcode, Func, 1'b1));
        Reset = 1'b1;
        MemReady = 1'b0;
        @(posedge CLK); #1;
        step("wd_reset_exit", 1, exp_out(0, Opcode, Func, 1'b0));
        Reset = 1'b0;

        // Reset while LW waits in MEMRD
        do_reset();
        Opcode = 6'b100011;
        MemReady = 1'b1;
        step("mid_fetch", 0, exp_out(0, Opcode, Func, 1'b1));
        step("mid_decode", 0, exp_out(1, Opcode, Func, 1'b1));
        step("mid_memadr", 0, exp_out(2, Opcode, Func, 1'b1));
        MemReady = 1'b0;
        step("mid_memrd", 0, exp_out(3, Opcode, Func, 1'b0));
        step("mid_memrd", 0, exp_out(3, Opcode, Func, 1'b0));
        Reset = 1'b1;
        @(posedge CLK); #1;
        step("reset_mid", 0, exp_out(0, Opcode, Func, 1'b0));
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
